// File: rtl/flag_cond_if.sv
// Flag/condition bus between the ALU/branch control side (master) and the
// flag_cond_unit (slave).
interface flag_cond_if;
    logic [4:0] alu_flags;
    logic       flag_we;
    logic       cond_valid;
    logic [3:0] cond;
    logic       push;
    logic       pop;
    logic [4:0] psr;
    logic       cin;
    logic       take_valid;
    logic       take;
    logic       stk_full;
    logic       stk_empty;
    logic       stk_err;

    // cond_valid has no ready: the unit always accepts it, and answers with a
    // take_valid pulse exactly one cycle later (take is meaningful only then).
    modport master (
        output alu_flags, flag_we, cond_valid, cond, push, pop,
        input  psr, cin, take_valid, take, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  alu_flags, flag_we, cond_valid, cond, push, pop,
        output psr, cin, take_valid, take, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/flag_cond_unit.sv
// Processor status register with ALU carry feedback, registered branch
// condition evaluation and a small PSR save stack for interrupt entry/exit.
module flag_cond_unit #(
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    flag_cond_if.slave bus
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    psr_q;
    logic [4:0]    psr_next;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_next;
    logic [4:0]    stk_mem [DEPTH];
    logic          take_valid_q;
    logic          take_q;
    logic          full_q;
    logic          empty_q;
    logic          err_q;

    logic          at_full;
    logic          at_empty;
    logic          push_req;
    logic          pop_req;
    logic          push_ok;
    logic          pop_ok;
    logic          err_set;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic [4:0]    eval_flags;

    // Flags are {Z,C,F,N,L}; N and L are the signed/unsigned less-than results.
    function automatic logic eval_cond(input logic [3:0] code, input logic [4:0] f);
        logic z, c, v, n, l;
        logic r;
        z = f[4];
        c = f[3];
        v = f[2];
        n = f[1];
        l = f[0];
        case (code)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = ~n;
            4'h3:    r = c;
            4'h4:    r = ~c;
            4'h5:    r = ~l & ~z;
            4'h6:    r = l | z;
            4'h7:    r = l;
            4'h8:    r = ~l;
            4'h9:    r = ~n & ~z;
            4'hA:    r = n | z;
            4'hB:    r = v;
            4'hC:    r = ~v;
            4'hD:    r = n;
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        at_full  = (ptr_q == PW'(DEPTH));
        at_empty = (ptr_q == '0);
        // Simultaneous push and pop cancel each other entirely.
        push_req = bus.push & ~bus.pop;
        pop_req  = bus.pop & ~bus.push;
        push_ok  = push_req & ~at_full;
        pop_ok   = pop_req & ~at_empty;
        err_set  = (push_req & at_full) | (pop_req & at_empty);
        wr_idx   = IW'(ptr_q);
        top_idx  = IW'(ptr_q - 1'b1);

        psr_next = psr_q;
        if (pop_ok) begin
            psr_next = stk_mem[top_idx];
        end else if (bus.flag_we) begin
            psr_next = bus.alu_flags;
        end

        ptr_next = ptr_q;
        if (push_ok) begin
            ptr_next = ptr_q + 1'b1;
        end else if (pop_ok) begin
            ptr_next = ptr_q - 1'b1;
        end

        eval_flags = BYPASS ? psr_next : psr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psr_q        <= '0;
            ptr_q        <= '0;
            take_valid_q <= 1'b0;
            take_q       <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            psr_q        <= psr_next;
            ptr_q        <= ptr_next;
            take_valid_q <= bus.cond_valid;
            take_q       <= bus.cond_valid ? eval_cond(bus.cond, eval_flags) : 1'b0;
            full_q       <= (ptr_next == PW'(DEPTH));
            empty_q      <= (ptr_next == '0);
            err_q        <= err_q | err_set;
        end
    end

    // Stack storage needs no reset; the pointer alone defines what is valid.
    // The saved value is the pre-edge psr, so a same-cycle flag_we is not seen.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            stk_mem[wr_idx] <= psr_q;
        end
    end

    assign bus.psr        = psr_q;
    assign bus.cin        = psr_q[3];
    assign bus.take_valid = take_valid_q;
    assign bus.take       = take_q;
    assign bus.stk_full   = full_q;
    assign bus.stk_empty  = empty_q;
    assign bus.stk_err    = err_q;
endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: directed scenarios with literal expectations and
// a queue-based status/stack model compared against the outputs every cycle.
module tb_flag_cond_unit;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    bit   cmp_en;

    flag_cond_if bus ();

    flag_cond_unit #(.DEPTH(DEPTH), .BYPASS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [4:0] m_psr;
    logic [4:0] m_stk[$];
    logic       m_err;
    logic       m_tv;
    logic       m_take;

    // Condition truth written from the mnemonic meanings.
    function automatic logic model_cond(input int code, input logic [4:0] f);
        bit z, c, v, n, l;
        bit eq, ne, slt, ult;
        z = f[4]; c = f[3]; v = f[2]; n = f[1]; l = f[0];
        eq = z; ne = !z; slt = n; ult = l;
        case (code)
            0:  return eq;
            1:  return ne;
            2:  return !slt;
            3:  return c;
            4:  return !c;
            5:  return !ult && ne;
            6:  return ult || eq;
            7:  return ult;
            8:  return !ult;
            9:  return !slt && ne;
            10: return slt || eq;
            11: return v;
            12: return !v;
            13: return slt;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        m_psr = '0; m_err = 0; m_tv = 0; m_take = 0;
    end

    always @(posedge clk) begin
        logic [4:0] nxt;
        bit popped;
        if (reset) begin
            m_psr = '0; m_err = 0; m_tv = 0; m_take = 0;
            m_stk.delete();
        end else begin
            nxt = m_psr;
            popped = 0;
            if (bus.pop && !bus.push) begin
                if (m_stk.size() == 0) m_err = 1;
                else begin
                    nxt = m_stk.pop_back();
                    popped = 1;
                end
            end
            if (!popped && bus.flag_we) nxt = bus.alu_flags;
            if (bus.push && !bus.pop) begin
                if (m_stk.size() == DEPTH) m_err = 1;
                else m_stk.push_back(m_psr);
            end
            m_tv   = bus.cond_valid;
            m_take = bus.cond_valid ? model_cond(int'(bus.cond), nxt) : 1'b0;
            m_psr  = nxt;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (cmp_en) begin
            check("psr", bus.psr, m_psr);
            check("cin", 5'(bus.cin), 5'(m_psr[3]));
            check("take_valid", 5'(bus.take_valid), 5'(m_tv));
            check("take", 5'(bus.take), 5'(m_take));
            check("stk_full", 5'(bus.stk_full), 5'(m_stk.size() == DEPTH));
            check("stk_empty", 5'(bus.stk_empty), 5'(m_stk.size() == 0));
            check("stk_err", 5'(bus.stk_err), 5'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit we, input logic [4:0] flags, input bit cv,
                         input logic [3:0] cd, input bit pu, input bit po);
        @(negedge clk);
        bus.flag_we    = we;
        bus.alu_flags  = flags;
        bus.cond_valid = cv;
        bus.cond       = cd;
        bus.push       = pu;
        bus.pop        = po;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 5'b0, 0, 4'h0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [4:0] vals [6];
        n_checks = 0;
        n_fail   = 0;
        cmp_en   = 0;
        reset    = 1'b1;
        bus.flag_we = 0; bus.alu_flags = '0; bus.cond_valid = 0;
        bus.cond = '0; bus.push = 0; bus.pop = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1;
        check("rst_psr", bus.psr, 5'b00000);
        check("rst_cin", 5'(bus.cin), 5'd0);
        check("rst_take_valid", 5'(bus.take_valid), 5'd0);
        check("rst_take", 5'(bus.take), 5'd0);
        check("rst_full", 5'(bus.stk_full), 5'd0);
        check("rst_empty", 5'(bus.stk_empty), 5'd1);
        check("rst_err", 5'(bus.stk_err), 5'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: capture Z
        cycle(1, 5'b10000, 0, 4'h0, 0, 0);
        check("t1_psr", bus.psr, 5'b10000);
        check("t1_cin", 5'(bus.cin), 5'd0);

        // 2: same-cycle forwarding into condition evaluation
        cycle(1, 5'b00011, 1, 4'hD, 0, 0);
        check("t2_lt_valid", 5'(bus.take_valid), 5'd1);
        check("t2_lt_take", 5'(bus.take), 5'd1);
        cycle(0, 5'b00000, 1, 4'h2, 0, 0);
        check("t2_ge_take", 5'(bus.take), 5'd0);
        idle();
        check("t2_valid_drop", 5'(bus.take_valid), 5'd0);

        // 3: save, overwrite, restore
        do_reset();
        cycle(1, 5'b01000, 0, 4'h0, 0, 0);
        cycle(0, 5'b00000, 0, 4'h0, 1, 0);
        check("t3_not_empty", 5'(bus.stk_empty), 5'd0);
        cycle(1, 5'b00000, 0, 4'h0, 0, 0);
        check("t3_cleared", bus.psr, 5'b00000);
        cycle(0, 5'b00000, 0, 4'h0, 0, 1);
        check("t3_psr", bus.psr, 5'b01000);
        check("t3_cin", 5'(bus.cin), 5'd1);
        check("t3_empty", 5'(bus.stk_empty), 5'd1);

        // push+pop together is ignored, flag_we still lands
        cycle(1, 5'b00101, 0, 4'h0, 1, 1);
        check("t3_pp_psr", bus.psr, 5'b00101);
        check("t3_pp_empty", 5'(bus.stk_empty), 5'd1);
        check("t3_pp_err", 5'(bus.stk_err), 5'd0);

        // 4: fill, overflow, LIFO drain, underflow
        do_reset();
        vals[0] = 5'b00001; vals[1] = 5'b00010; vals[2] = 5'b00100;
        vals[3] = 5'b01000; vals[4] = 5'b10000; vals[5] = 5'b11111;
        cycle(1, vals[0], 0, 4'h0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cycle(1, vals[i], 0, 4'h0, 1, 0);
            check("t4_full_fill", 5'(bus.stk_full), 5'(i == 4));
        end
        check("t4_err_before", 5'(bus.stk_err), 5'd0);
        cycle(1, vals[5], 0, 4'h0, 1, 0);
        check("t4_err_ovf", 5'(bus.stk_err), 5'd1);
        check("t4_full_ovf", 5'(bus.stk_full), 5'd1);
        check("t4_psr_ovf", bus.psr, 5'b11111);
        for (int i = 3; i >= 0; i--) begin
            cycle(0, 5'b00000, 0, 4'h0, 0, 1);
            check("t4_lifo", bus.psr, vals[i]);
        end
        check("t4_empty", 5'(bus.stk_empty), 5'd1);
        cycle(0, 5'b00000, 0, 4'h0, 0, 1);
        check("t4_underflow_psr", bus.psr, 5'b00001);
        cycle(1, 5'b10110, 0, 4'h0, 0, 1);
        check("t4_underflow_we", bus.psr, 5'b10110);
        check("t4_err_sticky", 5'(bus.stk_err), 5'd1);

        // 5: sweep all codes over all flag values (model checks every cycle)
        do_reset();
        for (int p = 0; p < 32; p++) begin
            for (int c = 0; c < 16; c++) begin
                cycle(1, 5'(p), 1, 4'(c), 0, 0);
                if (c == 14) check("t5_uc", 5'(bus.take), 5'd1);
                if (c == 15) check("t5_nv", 5'(bus.take), 5'd0);
            end
        end
        // a few hand-derived points: psr 10001 -> Z=1,L=1
        cycle(1, 5'b10001, 1, 4'h5, 0, 0);
        check("t5_hi_zl", 5'(bus.take), 5'd0);
        cycle(0, 5'b00000, 1, 4'h6, 0, 0);
        check("t5_ls_zl", 5'(bus.take), 5'd1);
        cycle(1, 5'b00100, 1, 4'hB, 0, 0);
        check("t5_fs", 5'(bus.take), 5'd1);
        cycle(1, 5'b00010, 1, 4'h9, 0, 0);
        check("t5_gt_neg", 5'(bus.take), 5'd0);

        // 6: reset squashes a pending result and clears sticky error
        cycle(0, 5'b00000, 0, 4'h0, 0, 1);
        cycle(0, 5'b00000, 0, 4'h0, 0, 1);
        cycle(1, 5'b01010, 1, 4'hE, 0, 0);
        check("t6_pending", 5'(bus.take_valid), 5'd1);
        @(negedge clk);
        reset = 1'b1;
        idle();
        check("t6_tv", 5'(bus.take_valid), 5'd0);
        check("t6_psr", bus.psr, 5'b00000);
        check("t6_err", 5'(bus.stk_err), 5'd0);
        check("t6_empty", 5'(bus.stk_empty), 5'd1);
        @(negedge clk);
        reset = 1'b0;
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
